// File: rtl/param_memory_pkg.sv
// Shared types for param_memory: sweep FSM
// states and collision-policy encodings.
package param_memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port,
// one combinational read port, no reset.
module mem_array #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_memory.sv
// Parameterised RAM with clear sweep, address
// range checks, collision policy and read pipe.
module param_memory
  import param_memory_pkg::*;
#(
  parameter  int W      = 8,
  parameter  int DEPTH  = 16,
  parameter  int MODE   = READ_FIRST,
  parameter  int RD_LAT = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          clr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          busy
);

  localparam logic [AW:0]   DEP  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;

  logic          go, wr_ok, rd_ok;
  logic          wr_hit, rd_acc, fwd;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata, rdat, rd_word;
  logic          v1;
  logic [W-1:0]  d1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    unique case (1'b1)
      (state == CLEAR): begin
        ptr_nx = ptr + AW'(1);
        if (ptr == LAST) begin
          state_nx = IDLE;
          ptr_nx   = '0;
        end
      end
      (state == IDLE): begin
        if (clr) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy  = (state == CLEAR);
    we    = busy | wr_hit;
    waddr = busy ? ptr : wr_addr;
    wdata = busy ? '0 : wr_data;
  end

  assign go     = (state == IDLE) && !clr;
  assign wr_ok  = {1'b0, wr_addr} < DEP;
  assign rd_ok  = {1'b0, rd_addr} < DEP;
  assign wr_hit = go && wr_en && wr_ok;
  assign rd_acc = go && rd_en;

  // write-first forwards the incoming word
  assign fwd = (MODE == WRITE_FIRST) && wr_hit
            && (wr_addr == rd_addr);

  always_comb begin
    rd_word = rdat;
    if (!rd_ok)   rd_word = '0;
    else if (fwd) rd_word = wr_data;
  end

  mem_array #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rdat)
  );

  // pipe runs independently of the FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) d1 <= rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic         v2;
      logic [W-1:0] d2;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end
      assign rd_valid = v2;
      assign rd_data  = d2;
    end else begin : g_lat1
      assign rd_valid = v1;
      assign rd_data  = d1;
    end
  endgenerate

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench: two configurations share
// random stimulus against a behavioural model.
module tb_param_memory;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
  logic [3:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;

  logic [7:0] rdd0, rdd1;
  logic       rv0, rv1, b0, b1;

  always #5 clk = ~clk;

  param_memory #(
    .W(8), .DEPTH(16), .MODE(0), .RD_LAT(1)
  ) u0 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .clr(clr),
    .rd_data(rdd0), .rd_valid(rv0), .busy(b0)
  );

  param_memory #(
    .W(8), .DEPTH(12), .MODE(1), .RD_LAT(2)
  ) u1 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .clr(clr),
    .rd_data(rdd1), .rd_valid(rv1), .busy(b1)
  );

  typedef struct {
    int         due;
    logic [7:0] d;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         dep  [2] = '{16, 12};
  int         lat  [2] = '{1, 2};
  int         mode [2] = '{0, 1};
  logic [7:0] mem  [2][16];
  int         ccnt [2];
  logic [7:0] last [2];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ccnt[k] = dep[k];
      last[k] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic step();
    int         a;
    int         r;
    exp_t       e;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      a = int'(wr_addr);
      r = int'(rd_addr);
      if (!reset) begin
        ccnt[k] = dep[k];
      end else if (ccnt[k] > 0) begin
        mem[k][dep[k] - ccnt[k]] = 8'h00;
        ccnt[k]--;
      end else if (clr) begin
        ccnt[k] = dep[k];
      end else begin
        e.due = cyc + lat[k] - 1;
        if (r >= dep[k]) e.d = 8'h00;
        else if (mode[k] == 1 && wr_en && a == r)
          e.d = wr_data;
        else e.d = mem[k][r];
        if (wr_en && a < dep[k]) mem[k][a] = wr_data;
        if (rd_en) begin
          if (k == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic we,
                      input logic [3:0] wa,
                      input logic [7:0] wd,
                      input logic re,
                      input logic [3:0] ra,
                      input logic c);
    @(negedge clk);
    reset   = r;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    clr     = c;
    if (!r) model_reset();
    @(posedge clk);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic check_dut(input int k, input logic v,
                           input logic [7:0] d,
                           input logic b);
    exp_t e;
    int   n;
    logic eb;
    eb = !reset || ccnt[k] > 0;
    chk($sformatf("busy%0d", k), 32'(b), 32'(eb));
    n = (k == 0) ? q0.size() : q1.size();
    if (v) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL unexp_valid%0d cyc=%0d got=1 want=0",
                 k, cyc);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("due%0d", k), 32'(cyc), 32'(e.due));
        chk($sformatf("data%0d", k), 32'(d), 32'(e.d));
        last[k] = e.d;
      end
    end else begin
      if (n > 0) begin
        e = (k == 0) ? q0[0] : q1[0];
        if (e.due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL miss_valid%0d cyc=%0d got=0 want=1",
                   k, cyc);
          if (k == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
      chk($sformatf("hold%0d", k), 32'(d), 32'(last[k]));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_dut(0, rv0, rdd0, b0);
      check_dut(1, rv1, rdd1, b1);
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++)
      tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);
    idle(17);
    for (int i = 0; i < 16; i++)
      tick(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'(i), 1'b0);
    tick(1'b1, 1'b1, 4'd0, 8'h03, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b1, 4'd5, 8'h06, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b0);
    tick(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0);
    idle(2);
    tick(1'b1, 1'b1, 4'd7, 8'h11, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b1, 4'd7, 8'h22, 1'b1, 4'd7, 1'b0);
    idle(2);
    tick(1'b1, 1'b1, 4'd13, 8'hAA, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd13, 1'b0);
    tick(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd11, 1'b0);
    idle(2);
    tick(1'b1, 1'b1, 4'd3, 8'h77, 1'b1, 4'd5, 1'b1);
    tick(1'b1, 1'b1, 4'd2, 8'h55, 1'b1, 4'd2, 1'b0);
    tick(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'h0, 1'b1);
    idle(16);
    for (int i = 0; i < 16; i++)
      tick(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'(i), 1'b0);
    idle(2);
    for (int i = 0; i < 400; i++)
      tick(1'b1, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 8'($urandom),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 59) == 0));
    idle(20);
    tick(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1);
    idle(4);
    tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);
    idle(17);
    tick(1'b1, 1'b1, 4'd4, 8'h5A, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'd4, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_busy0", 32'(b0), 32'd1);
    chk("async_busy1", 32'(b1), 32'd1);
    chk("async_rv0", 32'(rv0), 32'd0);
    chk("async_rv1", 32'(rv1), 32'd0);
    for (int i = 0; i < 3; i++)
      tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);
    idle(17);
    for (int i = 0; i < 60; i++)
      tick(1'b1, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 8'($urandom),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 1'b0);
    idle(4);
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 Parameter W, default 8, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 16, number of words (2..1024, need not be a power of two).
REQ-003 Parameter MODE, default 0, same-address collision policy: 0 = read-first, 1 = write-first.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles (1 or 2).
REQ-005 Derived constant AW = clog2(DEPTH), address width.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_addr  input  AW  write address.
REQ-010 wr_data  input  W  write data.
REQ-011 rd_en  input  1  read request.
REQ-012 rd_addr  input  AW  read address.
REQ-013 clr  input  1  one-cycle pulse; starts a full-array clear.
REQ-014 rd_data  output  W  read data; valid when rd_valid=1.
REQ-015 rd_valid  output  1  rd_data qualifier, one pulse per accepted read.
REQ-016 busy  output  1  high while the clear sweep runs; requests are ignored.

Function
REQ-017 The FSM SHALL have two states, CLEAR and IDLE; reset forces CLEAR with sweep pointer 0.
REQ-018 In CLEAR, each cycle SHALL write 0 to word[ptr] and increment ptr; after ptr = DEPTH-1 is written, the FSM SHALL enter IDLE on the next edge (exactly DEPTH cycles in CLEAR).
REQ-019 busy SHALL equal 1 in CLEAR and 0 in IDLE.
REQ-020 In IDLE, a clr=1 sample SHALL move the FSM to CLEAR with ptr=0; any wr_en/rd_en in the same cycle SHALL be ignored.
REQ-021 In CLEAR, wr_en, rd_en and clr SHALL be ignored (no write, no rd_valid, no restart).
REQ-022 In IDLE, wr_en=1 with wr_addr < DEPTH SHALL store wr_data at that edge; if wr_addr >= DEPTH, the write SHALL be dropped.
REQ-023 In IDLE, rd_en=1 SHALL produce rd_valid=1 exactly RD_LAT cycles after the sampling edge; rd_data = word[rd_addr], or 0 if rd_addr >= DEPTH.
REQ-024 Back-to-back reads SHALL be fully pipelined: one result per cycle, in order.
REQ-025 When wr_en and rd_en hit the same valid address in the same cycle, rd_data SHALL be the old word if MODE=0 and wr_data if MODE=1.
REQ-026 A read accepted before clr SHALL still complete with its pre-clear data, even if the FSM has entered CLEAR.
REQ-027 rd_data SHALL hold its last value while rd_valid=0.

Reset
REQ-028 reset=0 SHALL immediately, without a clock, set: rd_valid=0, rd_data=0, busy=1, FSM=CLEAR, ptr=0, read pipeline flushed.
REQ-029 Array contents are not reset asynchronously; they SHALL be zero after the post-reset sweep.
REQ-030 Reset asserted mid-sweep or mid-read SHALL abort and restart the sweep from ptr=0; no stale rd_valid SHALL appear.

Structure
REQ-031 Shared package param_memory_pkg SHALL hold the FSM state typedef (CLEAR, IDLE) and the MODE encodings (READ_FIRST=0, WRITE_FIRST=1).
REQ-032 Storage SHALL be a single sub-module mem_array (one write port, one read port, synchronous write, combinational read); param_memory contains the FSM, address checks, collision mux and latency pipeline.

Verification
REQ-033 Reset release, W=8, DEPTH=16: busy=1 for exactly 16 cycles; then reads of addresses 0..15 return 0.
REQ-034 Write 3@0 and 6@5, then read 0 and 5 on consecutive cycles with RD_LAT=1: rd_valid on two consecutive cycles, rd_data = 3, then 6.
REQ-035 Old word 0x11 at addr 7, write 0x22 and read addr 7 in the same cycle: MODE=0 returns 0x11; MODE=1 returns 0x22.
REQ-036 DEPTH=12: write 0xAA to addr 13 -> dropped; read addr 13 -> rd_valid=1 with rd_data=0; addr 11 unaffected.
REQ-037 clr pulse, then wr_en during busy: busy=1 for DEPTH cycles, the write is not stored, and afterwards all words read 0.
REQ-038 RD_LAT=2 with reset dropped one cycle after rd_en: rd_valid never asserts, and busy returns to 1 asynchronously.
